// File: rtl/i2c_config_sequencer_pkg.sv
// Shared types and constants for the sensor bring-up sequencer: FSM states,
// I2C word layout and elaboration-time sizing helpers.
package i2c_config_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_LOAD,
    ST_ARM,
    ST_WAIT_END,
    ST_CHECK,
    ST_DONE,
    ST_FAIL
  } state_e;

  // Layout of the 32-bit word handed to the I2C controller; the controller
  // decodes the same positions.
  localparam int WORD_W    = 32;
  localparam int LUT_W     = 24;
  localparam int SLAVE_MSB = 31;
  localparam int SLAVE_LSB = 24;
  localparam int SUB_MSB   = 23;
  localparam int SUB_LSB   = 16;
  localparam int DATA_MSB  = 15;
  localparam int DATA_LSB  = 0;

  // Half-period of CTRL_CLK in system cycles, never below 2.
  function automatic int calc_clk_div(input int clk_freq, input int i2c_freq);
    int d;
    d = clk_freq / (2 * i2c_freq);
    return (d < 2) ? 2 : d;
  endfunction

  // Bits needed to hold values 0..n-1, at least one bit.
  function automatic int calc_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2c_config_sequencer_if.sv
// Bundle between the sequencer, the I2C byte-write controller and the
// constant register table.
interface i2c_config_sequencer_if #(
  parameter int IDX_W = 5
) ();
  import i2c_config_sequencer_pkg::*;

  logic [WORD_W-1:0] I2C_DATA;
  logic              GO;
  logic              END;
  logic              ACK;
  logic [IDX_W-1:0]  LUT_INDEX;
  logic [LUT_W-1:0]  LUT_DATA;

  modport master (
    output I2C_DATA,
    output GO,
    output LUT_INDEX,
    input  END,
    input  ACK,
    input  LUT_DATA
  );

  modport slave (
    input  I2C_DATA,
    input  GO,
    input  LUT_INDEX,
    output END,
    output ACK,
    output LUT_DATA
  );

endinterface

// File: rtl/i2c_config_sequencer_clk_div.sv
// Free-running divider producing the controller clock and a one-cycle strobe
// on the system cycle where that clock falls.
module i2c_clk_div
  import i2c_config_sequencer_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic ctrl_clk_o,
  output logic tick_o
);

  localparam int CNT_W = calc_width(CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_W'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    clk_d = clk_q;
    if (wrap) begin
      cnt_d = '0;
      clk_d = ~clk_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign ctrl_clk_o = clk_q;
  // Falling edge of CTRL_CLK happens on the same system edge that consumes tick.
  assign tick_o     = wrap & clk_q;

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks the register table, handing one write per entry to the I2C controller
// with GO/END handshake, NACK retry and done/fail reporting.
module i2c_config_sequencer
  import i2c_config_sequencer_pkg::*;
#(
  parameter int          CLK_FREQ    = 50_000_000,
  parameter int          I2C_FREQ    = 20_000,
  parameter int          LUT_SIZE    = 24,
  parameter logic [7:0]  SLAVE_ADDR  = 8'hBA,
  parameter int          PWRUP_TICKS = 16,
  parameter int          MAX_RETRY   = 3
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic                          START,
  output logic                          CTRL_CLK,
  output logic                          CONFIG_DONE,
  output logic                          CONFIG_FAIL,
  i2c_config_sequencer_if.master        bus
);

  localparam int CLK_DIV = calc_clk_div(CLK_FREQ, I2C_FREQ);
  localparam int IDX_W   = calc_width(LUT_SIZE);
  localparam int RTY_W   = calc_width(MAX_RETRY + 1);
  localparam int PWR_W   = calc_width(PWRUP_TICKS);

  logic tick;

  i2c_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk_i      (CLOCK),
    .rst_ni     (RESET),
    .ctrl_clk_o (CTRL_CLK),
    .tick_o     (tick)
  );

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              go_q, go_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [PWR_W-1:0]  pwr_q, pwr_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic              restart;

  assign restart = START && ((state_q == ST_DONE) || (state_q == ST_FAIL));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    go_d    = go_q;
    retry_d = retry_q;
    pwr_d   = pwr_q;
    done_d  = done_q;
    fail_d  = fail_q;

    if (restart) begin
      // A coinciding tick is counted as the first power-up tick.
      state_d = ST_PWRUP;
      idx_d   = '0;
      retry_d = '0;
      done_d  = 1'b0;
      fail_d  = 1'b0;
      pwr_d   = tick ? PWR_W'(1) : '0;
    end else if (tick) begin
      unique case (state_q)
        ST_PWRUP: begin
          if (int'(pwr_q) >= PWRUP_TICKS - 1) begin
            pwr_d   = '0;
            state_d = ST_LOAD;
          end else begin
            pwr_d = pwr_q + 1'b1;
          end
        end
        ST_LOAD: begin
          data_d[SLAVE_MSB:SLAVE_LSB] = SLAVE_ADDR;
          data_d[SUB_MSB:SUB_LSB]     = bus.LUT_DATA[SUB_MSB:SUB_LSB];
          data_d[DATA_MSB:DATA_LSB]   = bus.LUT_DATA[DATA_MSB:DATA_LSB];
          go_d    = 1'b1;
          state_d = ST_ARM;
        end
        // END may still be high from the previous transfer until the
        // controller has seen GO, so wait for it to drop first.
        ST_ARM: begin
          if (!bus.END) state_d = ST_WAIT_END;
        end
        ST_WAIT_END: begin
          if (bus.END) begin
            go_d    = 1'b0;
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!bus.ACK) begin
            retry_d = '0;
            if (idx_q == IDX_W'(LUT_SIZE - 1)) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = ST_LOAD;
            end
          end else if (int'(retry_q) < MAX_RETRY) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_LOAD;
          end else begin
            fail_d  = 1'b1;
            state_d = ST_FAIL;
          end
        end
        ST_DONE, ST_FAIL: state_d = state_q;
        default:          state_d = ST_PWRUP;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_PWRUP;
      idx_q   <= '0;
      data_q  <= '0;
      go_q    <= 1'b0;
      retry_q <= '0;
      pwr_q   <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      go_q    <= go_d;
      retry_q <= retry_d;
      pwr_q   <= pwr_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.GO        = go_q;
  assign bus.I2C_DATA  = data_q;
  assign bus.LUT_INDEX = idx_q;
  assign CONFIG_DONE   = done_q;
  assign CONFIG_FAIL   = fail_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: behavioural I2C controller/slave, table model
// and per-cycle checker, plus a second instance for the full-rate divider.
module tb_i2c_config_sequencer;

  localparam int DIV   = 4;
  localparam int LUT_N = 4;
  localparam int MAXR  = 3;

  logic CLOCK, RESET, START;
  logic CTRL_CLK, CONFIG_DONE, CONFIG_FAIL;
  logic rst2_n, ctrl2, done2, fail2;

  int checks;
  int failures;
  int go_rises;
  int k_cyc;
  bit div_done;

  logic [23:0] lut [0:LUT_N-1] = '{24'h0A1234, 24'h0B5678, 24'h0C9ABC, 24'h0DDEF0};

  i2c_config_sequencer_if #(.IDX_W(2)) bus ();
  i2c_config_sequencer_if #(.IDX_W(1)) bus2 ();

  i2c_config_sequencer #(
    .CLK_FREQ(160_000), .I2C_FREQ(20_000), .LUT_SIZE(LUT_N),
    .SLAVE_ADDR(8'hBA), .PWRUP_TICKS(16), .MAX_RETRY(MAXR)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .CTRL_CLK(CTRL_CLK),
    .CONFIG_DONE(CONFIG_DONE), .CONFIG_FAIL(CONFIG_FAIL), .bus(bus)
  );

  i2c_config_sequencer #(
    .CLK_FREQ(50_000_000), .I2C_FREQ(20_000), .LUT_SIZE(1),
    .SLAVE_ADDR(8'hBA), .PWRUP_TICKS(1), .MAX_RETRY(MAXR)
  ) dut_div (
    .CLOCK(CLOCK), .RESET(rst2_n), .START(1'b0), .CTRL_CLK(ctrl2),
    .CONFIG_DONE(done2), .CONFIG_FAIL(fail2), .bus(bus2)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  assign bus.LUT_DATA  = lut[bus.LUT_INDEX];
  assign bus2.LUT_DATA = 24'h123456;
  assign bus2.END      = 1'b1;
  assign bus2.ACK      = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Controller/slave model: words captured at transfer start, NACK plan by entry.
  logic [31:0] cap_q[$];
  logic [31:0] exp_q[$];
  int  nack_entry;
  int  nack_count;
  int  ctl_cnt;
  logic pend_nack;
  logic exp_done, exp_fail;
  int  exp_idx;

  function automatic int count_word(input logic [31:0] w);
    int n;
    n = 0;
    foreach (cap_q[i]) if (cap_q[i] == w) n++;
    return n;
  endfunction

  function automatic logic nack_now(input logic [31:0] w);
    if (nack_entry < 0 || nack_entry >= LUT_N) return 1'b0;
    if (w[23:0] != lut[nack_entry]) return 1'b0;
    return (count_word(w) <= nack_count);
  endfunction

  always @(posedge CTRL_CLK or negedge RESET) begin
    if (!RESET) begin
      bus.END   <= 1'b1;
      bus.ACK   <= 1'b0;
      ctl_cnt   <= 0;
      pend_nack <= 1'b0;
    end else if (!bus.GO) begin
      ctl_cnt <= 0;
    end else if (ctl_cnt == 0) begin
      cap_q.push_back(bus.I2C_DATA);
      pend_nack <= nack_now(bus.I2C_DATA);
      bus.END   <= 1'b0;
      ctl_cnt   <= 1;
    end else if (ctl_cnt < 41) begin
      ctl_cnt <= ctl_cnt + 1;
      if (ctl_cnt == 40) begin
        bus.END <= 1'b1;
        bus.ACK <= pend_nack;
      end
    end
  end

  // Expected transfer list from the table rules.
  task automatic build_expect(input int ne, input int nc);
    int a;
    exp_q.delete();
    exp_done = 1'b0;
    exp_fail = 1'b0;
    exp_idx  = 0;
    for (int i = 0; i < LUT_N; i++) begin
      exp_idx = i;
      for (a = 0; a <= MAXR; a++) begin
        exp_q.push_back({8'hBA, lut[i]});
        if (!(i == ne && a < nc)) break;
      end
      if (a > MAXR) begin
        exp_fail = 1'b1;
        return;
      end
    end
    exp_done = 1'b1;
  endtask

  always @(posedge CLOCK or negedge RESET)
    if (!RESET) k_cyc <= 0;
    else        k_cyc <= k_cyc + 1;

  logic prev_go, prev_ck;
  logic [31:0] prev_data;
  bit skip = 1'b1;
  always @(negedge CLOCK) begin
    if (!RESET) begin
      skip = 1'b1;
    end else begin
      chk("ctrl_clk", {31'b0, CTRL_CLK}, 32'((k_cyc / DIV) % 2));
      if (!skip) begin
        if (bus.GO !== prev_go) chk("go_edge_on_fall", {30'b0, prev_ck, CTRL_CLK}, 32'd2);
        if (bus.GO && prev_go) chk("data_stable", bus.I2C_DATA, prev_data);
        if (bus.GO && !prev_go) go_rises++;
      end
      chk("flags_exclusive", {31'b0, CONFIG_DONE & CONFIG_FAIL}, 32'd0);
      skip = 1'b0;
    end
    prev_go   = bus.GO;
    prev_ck   = CTRL_CLK;
    prev_data = bus.I2C_DATA;
  end

  task automatic pulse_start();
    @(negedge CLOCK) START = 1'b1;
    @(negedge CLOCK) START = 1'b0;
  endtask

  task automatic wait_caps(input string nm, input int n);
    int c;
    c = 0;
    while (cap_q.size() < n && c < 4000) begin
      @(negedge CLOCK);
      c++;
    end
    chk({nm, "_wait"}, {31'b0, (c < 4000)}, 32'd1);
  endtask

  task automatic run_and_check(input string nm);
    int n;
    n = 0;
    while (!(CONFIG_DONE || CONFIG_FAIL) && n < 8000) begin
      @(negedge CLOCK);
      n++;
    end
    chk({nm, "_timeout"}, {31'b0, (n < 8000)}, 32'd1);
    chk({nm, "_count"}, cap_q.size(), exp_q.size());
    foreach (exp_q[i])
      chk($sformatf("%s_word%0d", nm, i), (i < cap_q.size()) ? cap_q[i] : 32'hxxxxxxxx, exp_q[i]);
    chk({nm, "_done"}, {31'b0, CONFIG_DONE}, {31'b0, exp_done});
    chk({nm, "_fail"}, {31'b0, CONFIG_FAIL}, {31'b0, exp_fail});
    chk({nm, "_index"}, {30'b0, bus.LUT_INDEX}, 32'(exp_idx));
  endtask

  initial begin
    int n1;
    checks = 0; failures = 0; go_rises = 0;
    RESET = 1'b0; START = 1'b0;
    nack_entry = -1; nack_count = 0;
    repeat (3) @(negedge CLOCK);
    chk("rst_go", {31'b0, bus.GO}, 32'd0);
    chk("rst_ctrl_clk", {31'b0, CTRL_CLK}, 32'd0);
    chk("rst_data", bus.I2C_DATA, 32'd0);
    chk("rst_index", {30'b0, bus.LUT_INDEX}, 32'd0);
    chk("rst_done", {31'b0, CONFIG_DONE}, 32'd0);
    chk("rst_fail", {31'b0, CONFIG_FAIL}, 32'd0);

    // Nominal run.
    build_expect(-1, 0);
    chk("nom_model_len", exp_q.size(), 32'd4);
    chk("nom_model_word0", exp_q[0], 32'hBA0A1234);
    #1 RESET = 1'b1;
    run_and_check("nom");
    chk("nom_go_pulses", go_rises, 32'd4);
    chk("nom_last_word", bus.I2C_DATA, 32'hBA0DDEF0);

    // Single NACK on entry 2.
    nack_entry = 2; nack_count = 1;
    build_expect(2, 1);
    chk("nack1_model_len", exp_q.size(), 32'd5);
    cap_q.delete(); go_rises = 0;
    pulse_start();
    chk("nack1_done_low", {31'b0, CONFIG_DONE}, 32'd0);
    run_and_check("nack1");
    chk("nack1_go_pulses", go_rises, 32'd5);
    chk("nack1_entry2_sends", count_word(32'hBA0C9ABC), 32'd2);

    // Persistent NACK on entry 1.
    nack_entry = 1; nack_count = 99;
    build_expect(1, 99);
    chk("fail_model_len", exp_q.size(), 32'd5);
    cap_q.delete(); go_rises = 0;
    pulse_start();
    run_and_check("fail");
    chk("fail_entry1_sends", count_word(32'hBA0B5678), 32'd4);
    chk("fail_index_lit", {30'b0, bus.LUT_INDEX}, 32'd1);

    // Rerun from FAIL; START during the run must be ignored.
    nack_entry = -1; nack_count = 0;
    build_expect(-1, 0);
    cap_q.delete(); go_rises = 0;
    pulse_start();
    chk("rerun_fail_low", {31'b0, CONFIG_FAIL}, 32'd0);
    wait_caps("ign", 1);
    pulse_start();
    run_and_check("ign");
    chk("ign_go_pulses", go_rises, 32'd4);

    // Rerun from DONE, then reset in the middle of entry 2.
    cap_q.delete(); go_rises = 0;
    pulse_start();
    chk("rerun_done_low", {31'b0, CONFIG_DONE}, 32'd0);
    wait_caps("rst", 3);
    chk("rst_mid_done_low", {31'b0, CONFIG_DONE}, 32'd0);
    n1 = 0;
    while (CTRL_CLK !== 1'b1 && n1 < 20) begin
      @(negedge CLOCK);
      n1++;
    end
    chk("rst_pre_go", {31'b0, bus.GO}, 32'd1);
    chk("rst_pre_index", {30'b0, bus.LUT_INDEX}, 32'd2);
    #2 RESET = 1'b0;
    #1;
    chk("rst_mid_go", {31'b0, bus.GO}, 32'd0);
    chk("rst_mid_ctrl_clk", {31'b0, CTRL_CLK}, 32'd0);
    chk("rst_mid_flags", {30'b0, CONFIG_DONE, CONFIG_FAIL}, 32'd0);
    chk("rst_mid_index", {30'b0, bus.LUT_INDEX}, 32'd0);
    repeat (3) @(negedge CLOCK);
    cap_q.delete(); go_rises = 0;
    #1 RESET = 1'b1;
    run_and_check("after_rst");
    chk("after_rst_go_pulses", go_rises, 32'd4);

    n1 = 0;
    while (!div_done && n1 < 20000) begin
      @(negedge CLOCK);
      n1++;
    end
    chk("div_finished", {31'b0, div_done}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Full-rate divider: 1250-cycle half period, GO moving only on falling edges.
  initial begin
    int rise[$];
    int fall[$];
    int go_edges;
    logic pc, pg;
    div_done = 1'b0;
    go_edges = 0;
    pc = 1'b0; pg = 1'b0;
    rst2_n = 1'b0;
    repeat (2) @(negedge CLOCK);
    #1 rst2_n = 1'b1;
    for (int c = 1; c <= 9000; c++) begin
      @(negedge CLOCK);
      if (ctrl2 && !pc) rise.push_back(c);
      if (!ctrl2 && pc) fall.push_back(c);
      if (bus2.GO !== pg) begin
        go_edges++;
        chk("div_go_on_fall", {30'b0, pc, ctrl2}, 32'd2);
      end
      pc = ctrl2;
      pg = bus2.GO;
    end
    chk("div_first_rise", (rise.size() >= 1) ? rise[0] : -1, 32'd1250);
    chk("div_period", (rise.size() >= 2) ? rise[1] - rise[0] : -1, 32'd2500);
    chk("div_high_time", (rise.size() >= 1 && fall.size() >= 1) ? fall[0] - rise[0] : -1, 32'd1250);
    chk("div_low_time", (rise.size() >= 2 && fall.size() >= 1) ? rise[1] - fall[0] : -1, 32'd1250);
    chk("div_go_edges", go_edges, 32'd1);
    div_done = 1'b1;
  end

endmodule

// File: doc/i2c_config_sequencer.md
# i2c_config_sequencer

Drives the I2C byte-write engine from a table of register writes to bring the image sensor up after reset. It generates the slow I2C controller clock from the system clock and presents one 32-bit word per transfer with a GO/END handshake. It checks ACK, retries failed writes and reports done or fail to the capture pipeline. It sits directly upstream of the I2C controller and downstream of a constant register table (LUT).

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- I2C_FREQ, 20_000: CTRL_CLK frequency in Hz. CLK_DIV = CLK_FREQ/(2·I2C_FREQ), minimum 2.
- LUT_SIZE, 24: number of table entries; entries are indexed 0..LUT_SIZE-1.
- SLAVE_ADDR, 8'hBA: 8-bit write address of the device.
- PWRUP_TICKS, 16: CTRL_CLK periods to wait after reset or START before the first write.
- MAX_RETRY, 3: maximum re-attempts per entry after a NACK.

Ports:
- CLOCK in 1: system clock.
- RESET in 1: asynchronous, active-low reset.
- START in 1: one-cycle pulse that re-runs the whole table. Ignored unless the block is in DONE or FAIL.
- CTRL_CLK out 1: divided clock fed to the controller's clock input.
- LUT_INDEX out ceil(log2(LUT_SIZE)): table address.
- LUT_DATA in 24: table entry. Bits [23:16] are the sub-address, [15:0] are the data.
- I2C_DATA out 32: word to the controller, {SLAVE_ADDR, LUT_DATA}.
- GO out 1: transfer request, level-sensitive.
- END in 1: transfer complete from the controller.
- ACK in 1: OR of the sampled ACK bits from the controller; 1 means NACK.
- CONFIG_DONE out 1: all entries written and acknowledged.
- CONFIG_FAIL out 1: one entry exhausted its retries.

## Operation
- Divider: counter 0..CLK_DIV-1. CTRL_CLK toggles when the counter wraps.
  - tick = the system cycle on which CTRL_CLK goes 1→0.
  - The FSM advances, samples END/ACK and updates GO/I2C_DATA/LUT_INDEX only on tick. This keeps outputs stable for half a period before the controller's rising edge.
- FSM states: PWRUP, LOAD, ARM, WAIT_END, CHECK, DONE, FAIL.
  - PWRUP: count PWRUP_TICKS ticks, then go to LOAD.
  - LOAD: latch I2C_DATA = {SLAVE_ADDR, LUT_DATA}, set GO=1, go to ARM.
  - ARM: wait for END==0 (controller has started), then go to WAIT_END.
  - WAIT_END: wait for END==1, then set GO=0 and go to CHECK.
  - CHECK, ACK==0: clear the retry count.
    - If LUT_INDEX==LUT_SIZE-1, go to DONE.
    - Otherwise increment LUT_INDEX and go to LOAD.
  - CHECK, ACK==1 and retry count < MAX_RETRY: increment the retry count and go to LOAD with the same index.
  - CHECK, ACK==1 and retry count == MAX_RETRY: go to FAIL.
  - DONE: CONFIG_DONE=1. FAIL: CONFIG_FAIL=1. Both hold until START or reset.
  - START while in DONE or FAIL: clear the flags, set LUT_INDEX=0, go to PWRUP.
- GO must drop to 0 for at least one tick between transfers. That is guaranteed by the CHECK state, which lets the controller's counter rearm.
- The retry counter is ceil(log2(MAX_RETRY+1)) bits wide and saturates.

## Timing
- Reset values:
  - CTRL_CLK=0, divider=0, GO=0, I2C_DATA=0, LUT_INDEX=0.
  - CONFIG_DONE=0, CONFIG_FAIL=0, state=PWRUP, retry=0.
- Reset applies immediately, including mid-transfer. GO drops asynchronously, and the controller aborts on its own GO=0.
- LUT_DATA is sampled on the LOAD tick. The table must be valid one system cycle after LUT_INDEX changes.
- Per-entry latency: at least 43 CTRL_CLK periods from the LOAD tick to the CHECK tick. The controller takes 41 counts and the handshake adds the rest.
- END already high when entering ARM, because the controller has not yet seen GO, is ignored.
- END and ACK are only meaningful on ticks. Values between ticks are ignored.
- START in the same cycle as a tick: the tick is taken in the restart state (PWRUP).

## Structure
- A shared package holds:
  - the FSM state enum;
  - a localparam function computing CLK_DIV and index widths;
  - the bit positions of the 32-bit I2C word (slave [31:24], sub [23:16], data [15:0]). The controller uses the same positions.
- Sub-module: i2c_clk_div (counter, CTRL_CLK, tick strobe). The FSM and the datapath stay in the top level.

## Test plan
- Nominal run with CLK_DIV=4, LUT_SIZE=4, an always-ACK slave model plus the real controller:
  - 4 transfers carry I2C_DATA={8'hBA, entry}.
  - CONFIG_DONE rises after the 4th CHECK; LUT_INDEX ends at 3.
- Single NACK on entry 2, then ACK: entry 2 is sent twice and CONFIG_DONE=1. Total GO pulses = 5.
- Persistent NACK on entry 1 with MAX_RETRY=3: entry 1 is sent 4 times, CONFIG_FAIL=1, CONFIG_DONE=0, LUT_INDEX holds 1.
- RESET asserted mid-transfer of entry 2: GO, CTRL_CLK and the flags go to 0 within the same cycle. After release the run restarts from PWRUP at index 0.
- START pulsed during a run is ignored. START pulsed in DONE re-runs all 4 entries, and CONFIG_DONE is low during the rerun.
- Divider check with CLK_DIV=1250: the CTRL_CLK period is 2500 CLOCK cycles with a 50% duty cycle, and GO edges align only with CTRL_CLK falling edges.
